// File: rtl/bjack_table_seq.sv
// bjack_table_seq: multi-seat blackjack round sequencer sharing one card generator
// Ports: SYS_CLK/RES clock and async active-high reset; START begins a round from idle/done;
// CARD_REQ/CARD_VLD/CARD card-generator handshake; HIT/STAND per-seat level requests;
// TURN one-hot active hand (MSB = dealer); DEAL_VLD/DEAL_IDX/DEAL_VAL applied-card pulse;
// TOTAL/BUST_V per-hand effective totals and bust flags; WIN_V/PUSH_V/DONE round results.
module bjack_table_seq #(
  parameter int NUM_SEATS    = 2,
  parameter int DEALER_STAND = 17
) (
  input  logic                       SYS_CLK,
  input  logic                       RES,
  input  logic                       START,
  output logic                       CARD_REQ,
  input  logic                       CARD_VLD,
  input  logic [3:0]                 CARD,
  input  logic [NUM_SEATS-1:0]       HIT,
  input  logic [NUM_SEATS-1:0]       STAND,
  output logic [NUM_SEATS:0]         TURN,
  output logic                       DEAL_VLD,
  output logic [2:0]                 DEAL_IDX,
  output logic [3:0]                 DEAL_VAL,
  output logic [5*(NUM_SEATS+1)-1:0] TOTAL,
  output logic [NUM_SEATS:0]         BUST_V,
  output logic [NUM_SEATS-1:0]       WIN_V,
  output logic [NUM_SEATS-1:0]       PUSH_V,
  output logic                       DONE
);
  localparam int H = NUM_SEATS + 1;
  localparam logic [2:0] DLR = 3'(NUM_SEATS);
  localparam logic [3:0] LAST_DEAL = 4'(2 * H - 1);
  localparam logic [4:0] STAND_AT = 5'(DEALER_STAND);
  typedef enum logic [2:0] {S_IDLE, S_DEAL, S_PLAY, S_HIT_REQ, S_DLR_REQ, S_SCORE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] seat_q, seat_d;
  logic [3:0] cnt_q, cnt_d;
  logic card_req_q, card_req_d, deal_vld_q, deal_vld_d;
  logic [2:0] deal_idx_q, deal_idx_d;
  logic [3:0] deal_val_q, deal_val_d;
  logic [4:0] sum_q [H];
  logic [4:0] sum_d [H];
  logic [H-1:0] ace_q, ace_d;
  logic [NUM_SEATS-1:0] win_q, win_d, push_q, push_d;
  logic [4:0] eff [H];
  logic [H-1:0] bust;
  logic [4:0] cur_eff;
  logic cur_bust, cur_hit, cur_stand, accept, start_ok, all_bust, seat_done, req_state;
  logic [3:0] card_val;
  assign accept    = card_req_q && CARD_VLD && CARD != 4'd0;
  assign card_val  = CARD > 4'd10 ? 4'd10 : CARD;
  assign start_ok  = (state_q == S_IDLE || state_q == S_DONE) && START;
  assign all_bust  = &bust[NUM_SEATS-1:0];
  // a seat leaves play on its own once it is bust or sitting on 21
  assign seat_done = cur_bust || cur_eff == 5'd21 || cur_stand;
  assign req_state = state_q == S_DEAL || state_q == S_HIT_REQ || state_q == S_DLR_REQ;
  always_comb begin
    for (int i = 0; i < H; i++) begin
      eff[i]  = (ace_q[i] && sum_q[i] <= 5'd11) ? sum_q[i] + 5'd10 : sum_q[i];
      bust[i] = sum_q[i] > 5'd21;
    end
  end
  // view of the active seat; dealer turn is handled separately via index NUM_SEATS
  always_comb begin
    cur_eff   = '0;
    cur_bust  = 1'b0;
    cur_hit   = 1'b0;
    cur_stand = 1'b0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (seat_q == 3'(i)) begin
        cur_eff   = eff[i];
        cur_bust  = bust[i];
        cur_hit   = HIT[i];
        cur_stand = STAND[i];
      end
    end
  end
  always_ff @(posedge SYS_CLK or posedge RES) begin
    if (RES) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = START ? S_DEAL : state_q;
      S_DEAL: state_d = (accept && cnt_q == LAST_DEAL) ? S_PLAY : S_DEAL;
      S_PLAY: begin
        if (seat_q == DLR) state_d = (all_bust || eff[NUM_SEATS] >= STAND_AT) ? S_SCORE : S_DLR_REQ;
        else if (!seat_done && cur_hit) state_d = S_HIT_REQ;
      end
      S_HIT_REQ, S_DLR_REQ: state_d = accept ? S_PLAY : state_q;
      S_SCORE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // datapath next-state: card application, turn advance, scoring and round clear
  always_comb begin
    seat_d     = seat_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    ace_d      = ace_q;
    win_d      = win_q;
    push_d     = push_q;
    deal_vld_d = accept;
    deal_idx_d = accept ? seat_q : deal_idx_q;
    deal_val_d = accept ? card_val : deal_val_q;
    card_req_d = req_state && !accept;
    if (accept) begin
      for (int i = 0; i < H; i++) begin
        if (seat_q == 3'(i) && sum_q[i] <= 5'd21) begin
          sum_d[i] = sum_q[i] + 5'(card_val);
          ace_d[i] = ace_q[i] | (card_val == 4'd1);
        end
      end
      if (state_q == S_DEAL) begin
        cnt_d  = cnt_q + 4'd1;
        seat_d = seat_q == DLR ? 3'd0 : seat_q + 3'd1;
      end
    end
    if (state_q == S_PLAY && seat_q != DLR && seat_done) seat_d = seat_q + 3'd1;
    if (state_q == S_SCORE) begin
      for (int i = 0; i < NUM_SEATS; i++) begin
        win_d[i]  = !bust[i] && (bust[NUM_SEATS] || eff[i] > eff[NUM_SEATS]);
        push_d[i] = !bust[i] && !bust[NUM_SEATS] && eff[i] == eff[NUM_SEATS];
      end
    end
    if (start_ok) begin
      for (int i = 0; i < H; i++) sum_d[i] = '0;
      ace_d  = '0;
      win_d  = '0;
      push_d = '0;
      seat_d = '0;
      cnt_d  = '0;
    end
  end
  always_ff @(posedge SYS_CLK or posedge RES) begin
    if (RES) begin
      seat_q     <= '0;
      cnt_q      <= '0;
      card_req_q <= 1'b0;
      deal_vld_q <= 1'b0;
      deal_idx_q <= '0;
      deal_val_q <= '0;
      for (int i = 0; i < H; i++) sum_q[i] <= '0;
      ace_q      <= '0;
      win_q      <= '0;
      push_q     <= '0;
    end else begin
      seat_q     <= seat_d;
      cnt_q      <= cnt_d;
      card_req_q <= card_req_d;
      deal_vld_q <= deal_vld_d;
      deal_idx_q <= deal_idx_d;
      deal_val_q <= deal_val_d;
      sum_q      <= sum_d;
      ace_q      <= ace_d;
      win_q      <= win_d;
      push_q     <= push_d;
    end
  end
  always_comb begin
    TURN     = (state_q == S_PLAY || state_q == S_HIT_REQ || state_q == S_DLR_REQ) ? H'(1) << seat_q : '0;
    CARD_REQ = card_req_q;
    DEAL_VLD = deal_vld_q;
    DEAL_IDX = deal_idx_q;
    DEAL_VAL = deal_val_q;
    BUST_V   = bust;
    WIN_V    = win_q;
    PUSH_V   = push_q;
    DONE     = state_q == S_DONE;
    TOTAL    = '0;
    for (int i = 0; i < H; i++) TOTAL[5*i +: 5] = eff[i];
  end
endmodule

// File: tb/tb_bjack_table_seq.sv
// tb_bjack_table_seq: randomized self-checking bench for bjack_table_seq against a card-list hand model
module tb_bjack_table_seq;
  localparam int NS = 2;
  localparam int H = NS + 1;
  logic SYS_CLK = 1'b0, RES = 1'b1, START = 1'b0, CARD_VLD = 1'b0;
  logic [3:0] CARD = 4'd0;
  logic [NS-1:0] HIT = '0, STAND = '0;
  logic CARD_REQ, DEAL_VLD, DONE;
  logic [NS:0] TURN, BUST_V;
  logic [2:0] DEAL_IDX;
  logic [3:0] DEAL_VAL;
  logic [5*H-1:0] TOTAL;
  logic [NS-1:0] WIN_V, PUSH_V;
  int n_chk = 0, n_err = 0;
  int hc [H][32];
  int hn [H];
  int cq [$];
  int dq [$];
  bjack_table_seq #(.NUM_SEATS(NS), .DEALER_STAND(17)) dut (
    .SYS_CLK(SYS_CLK), .RES(RES), .START(START), .CARD_REQ(CARD_REQ), .CARD_VLD(CARD_VLD),
    .CARD(CARD), .HIT(HIT), .STAND(STAND), .TURN(TURN), .DEAL_VLD(DEAL_VLD), .DEAL_IDX(DEAL_IDX),
    .DEAL_VAL(DEAL_VAL), .TOTAL(TOTAL), .BUST_V(BUST_V), .WIN_V(WIN_V), .PUSH_V(PUSH_V), .DONE(DONE)
  );
  always #5 SYS_CLK = ~SYS_CLK;
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int raw_of(int h);
    int s = 0;
    for (int j = 0; j < hn[h]; j++) s += hc[h][j];
    return s;
  endfunction
  function automatic int tot_of(int h);
    int s = raw_of(h);
    bit a = 0;
    for (int j = 0; j < hn[h]; j++) if (hc[h][j] == 1) a = 1;
    return (a && s + 10 <= 21) ? s + 10 : s;
  endfunction
  function automatic logic [NS:0] bust_vec();
    logic [NS:0] b = '0;
    for (int h = 0; h < H; h++) b[h] = raw_of(h) > 21;
    return b;
  endfunction
  function automatic logic [5*H-1:0] total_vec();
    logic [5*H-1:0] t = '0;
    for (int h = 0; h < H; h++) t[5*h +: 5] = 5'(tot_of(h));
    return t;
  endfunction
  function automatic logic [3:0] next_card();
    if (cq.size() > 0) return 4'(cq.pop_front());
    return 4'($urandom_range(1, 15));
  endfunction
  task automatic give_card(input logic [3:0] code, input int h);
    int n = 0;
    int v = code > 4'd10 ? 10 : int'(code);
    if (!CARD_REQ && $urandom_range(0, 3) == 0) begin
      CARD_VLD = 1'b1;
      CARD = 4'd7;
      step();
      CARD_VLD = 1'b0;
      chk("stray_vld", 32'(DEAL_VLD), 0);
    end
    while (!CARD_REQ && n < 20) begin
      step();
      n++;
    end
    if (!CARD_REQ) begin
      chk("req_timeout", 0, 1);
      return;
    end
    if ($urandom_range(0, 3) == 0) begin
      CARD_VLD = 1'b1;
      CARD = 4'd0;
      step();
      chk("inv_vld", 32'(DEAL_VLD), 0);
      chk("inv_req", 32'(CARD_REQ), 1);
    end
    CARD_VLD = 1'b1;
    CARD = code;
    step();
    CARD_VLD = 1'b0;
    CARD = 4'd0;
    if (hn[h] < 32) begin
      hc[h][hn[h]] = v;
      hn[h]++;
    end
    chk("deal_vld", 32'(DEAL_VLD), 1);
    chk("deal_idx", 32'(DEAL_IDX), 32'(h));
    chk("deal_val", 32'(DEAL_VAL), 32'(v));
    chk("req_drop", 32'(CARD_REQ), 0);
    chk("hand_total", 32'(TOTAL[5*h +: 5]), 32'(tot_of(h)));
    chk("bust_v", 32'(BUST_V), 32'(bust_vec()));
  endtask
  task automatic run_round();
    int k = 0, d = 0, n = 0;
    bit all_b, saw;
    logic [NS-1:0] ew, ep;
    for (int h = 0; h < H; h++) hn[h] = 0;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_done", 32'(DONE), 0);
    chk("start_total", 32'(TOTAL), 0);
    chk("start_win", 32'(WIN_V), 0);
    for (int c = 0; c < 2 * H; c++) give_card(next_card(), c % H);
    while (k < NS && n < 60) begin
      n++;
      chk("turn_seat", 32'(TURN), 32'(1 << k));
      if (raw_of(k) > 21 || tot_of(k) == 21) begin
        step();
        k++;
      end else begin
        d = dq.size() > 0 ? dq.pop_front() : (tot_of(k) <= 11 ? 1 : int'($urandom_range(0, 2)));
        if (d == 1) begin
          HIT = NS'(1 << k);
          step();
          HIT = '0;
          give_card(next_card(), k);
        end else begin
          STAND = NS'(1 << k);
          HIT = d == 2 ? NS'(1 << k) : (NS'($urandom) & ~NS'(1 << k));
          step();
          STAND = '0;
          HIT = '0;
          chk("held_req", 32'(CARD_REQ), 0);
          k++;
        end
      end
    end
    chk("turn_dlr", 32'(TURN), 32'(1 << NS));
    all_b = 1;
    for (int s = 0; s < NS; s++) if (raw_of(s) <= 21) all_b = 0;
    n = 0;
    while (!all_b && tot_of(NS) < 17 && n < 20) begin
      give_card(next_card(), NS);
      n++;
    end
    n = 0;
    saw = 0;
    while (!DONE && n < 10) begin
      if (CARD_REQ) saw = 1;
      step();
      n++;
    end
    chk("extra_req", 32'(saw), 0);
    chk("done", 32'(DONE), 1);
    chk("turn_done", 32'(TURN), 0);
    for (int s = 0; s < NS; s++) begin
      ew[s] = raw_of(s) <= 21 && (raw_of(NS) > 21 || tot_of(s) > tot_of(NS));
      ep[s] = raw_of(s) <= 21 && raw_of(NS) <= 21 && tot_of(s) == tot_of(NS);
    end
    chk("win_v", 32'(WIN_V), 32'(ew));
    chk("push_v", 32'(PUSH_V), 32'(ep));
    chk("final_total", 32'(TOTAL), 32'(total_vec()));
    chk("final_bust", 32'(BUST_V), 32'(bust_vec()));
    repeat (3) step();
    chk("hold_total", 32'(TOTAL), 32'(total_vec()));
    chk("hold_done", 32'(DONE), 1);
  endtask
  initial begin
    int n = 0;
    repeat (2) step();
    chk("rst_ctl", {CARD_REQ, DEAL_VLD, DONE}, 0);
    chk("rst_turn", 32'(TURN), 0);
    chk("rst_total", 32'(TOTAL), 0);
    chk("rst_flags", {BUST_V, WIN_V, PUSH_V}, 0);
    RES = 1'b0;
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    while (!CARD_REQ && n < 10) begin
      step();
      n++;
    end
    chk("pre_rst_req", 32'(CARD_REQ), 1);
    #2 RES = 1'b1;
    #1;
    chk("async_req", 32'(CARD_REQ), 0);
    chk("async_turn", 32'(TURN), 0);
    chk("async_done", 32'(DONE), 0);
    #2 RES = 1'b0;
    cq = '{10, 9, 7, 5, 8, 6, 5};
    dq = '{0, 0};
    run_round();
    cq = '{1, 10, 10, 6, 7, 7, 10, 5};
    dq = '{1, 1, 0};
    run_round();
    cq = '{10, 10, 5, 6, 6, 5, 10, 10};
    dq = '{1, 1};
    run_round();
    cq = '{9, 8, 1, 9, 12, 6};
    dq = '{0, 2};
    run_round();
    cq.delete();
    dq.delete();
    repeat (25) run_round();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bjack_table_seq.md
Name: bjack_table_seq

Overview:
- Round sequencer for a multi-seat blackjack table.
- Shares the single card generator among NUM_SEATS player seats and the dealer.
- Deals the opening hands, grants turns in seat order, accumulates every hand with ace handling, runs the dealer's draw rule and scores each seat.
- Sits between the card generator and the per-seat display/BCD/LED logic; replaces per-hand sequencing when more than one player is seated.

Parameters:
- NUM_SEATS, 2, number of player seats (1..4); the dealer is an extra internal hand.
- DEALER_STAND, 17, dealer stops drawing when its effective total is >= this value (stands on soft 17).

Ports:
- SYS_CLK  in  1  system clock; all state changes on the rising edge.
- RES  in  1  asynchronous, active-high reset.
- START  in  1  level; sampled in IDLE or DONE to begin a round.
- CARD_REQ  out  1  request to the card generator.
- CARD_VLD  in  1  generator card-valid strobe.
- CARD  in  4  card code: 1 = ace, 2..10 = face value, 11..15 = 10, 0 = invalid.
- HIT  in  NUM_SEATS  per-seat hit request, level.
- STAND  in  NUM_SEATS  per-seat stand request, level.
- TURN  out  NUM_SEATS+1  one-hot active hand; bit NUM_SEATS is the dealer; all zero outside play.
- DEAL_VLD  out  1  one-cycle pulse when a card has been applied to a hand.
- DEAL_IDX  out  3  hand index for DEAL_VLD (NUM_SEATS = dealer).
- DEAL_VAL  out  4  normalised card value 1..10.
- TOTAL  out  5*(NUM_SEATS+1)  effective total per hand; hand i is at bits [5i+4:5i].
- BUST_V  out  NUM_SEATS+1  per-hand bust flags.
- WIN_V  out  NUM_SEATS  seat beats dealer; valid while DONE = 1.
- PUSH_V  out  NUM_SEATS  seat ties dealer; valid while DONE = 1.
- DONE  out  1  high from scoring until the next round starts.

Behaviour:
- Reset (async, RES = 1):
  - State IDLE; all outputs 0, including CARD_REQ and TURN.
  - All sums, ace flags and result flags cleared.
  - A reset mid-handshake drops CARD_REQ immediately.
- Hand arithmetic:
  - Per hand: raw sum S (5 bits) and ace flag A.
  - Effective total = S + 10 if A = 1 and S <= 11, else S.
  - Bust when S > 21.
  - S cannot exceed 31: a card is only added while S <= 21, so the maximum is 21 + 10.
- Card handshake:
  - CARD_REQ rises the cycle after the FSM enters a REQ state and stays high until a cycle with CARD_VLD = 1 and CARD != 0.
  - In that cycle the card is accepted. In the following cycle: CARD_REQ = 0, DEAL_VLD pulses, and the hand and totals are updated.
  - CARD = 0 with CARD_VLD = 1 is ignored; CARD_REQ stays high.
  - CARD_VLD while CARD_REQ = 0 is ignored.
- FSM states: IDLE, DEAL, PLAY, HIT_REQ, DLR_REQ, SCORE, DONE.
- IDLE / DONE:
  - START = 1 clears all hands and result flags, drops DONE and enters DEAL.
  - START in any other state is ignored.
- DEAL:
  - 2*(NUM_SEATS+1) cards are dealt in the order seat0..seatN-1, dealer, then the same order again.
  - Then go to PLAY with TURN = seat0.
- PLAY (seat k):
  - STAND[k] = 1 marks the seat held and advances TURN to seat k+1.
  - HIT[k] = 1 goes to HIT_REQ; the card goes to seat k, then return to PLAY with the same seat.
  - STAND and HIT together: STAND wins.
  - The seat auto-advances without input when it is bust or its effective total = 21, including a natural 21 at deal.
  - HIT/STAND bits of non-active seats are ignored.
  - After the last seat, TURN = dealer bit.
- Dealer:
  - If every seat is bust, go straight to SCORE.
  - Otherwise, while the effective total < DEALER_STAND, go to DLR_REQ and draw. Then SCORE.
- SCORE (one cycle), per seat:
  - WIN = !bust_s & (bust_d | eff_s > eff_d).
  - PUSH = !bust_s & !bust_d & eff_s == eff_d.
  - Next state DONE; DONE = 1; TURN = 0.
- Totals and flags stay stable in DONE until the next START.

Test Plan:
- Reset mid-request: assert RES while CARD_REQ = 1 -> CARD_REQ, TURN, DONE = 0 asynchronously; START afterwards runs a clean round.
- NUM_SEATS = 2, cards 10,9,7 / 5,8,6, seat0 STAND, seat1 STAND:
  - TOTAL = 15, 17, 13; dealer draws 5 -> 18.
  - WIN_V = 00, PUSH_V = 00.
- Soft ace: seat0 dealt 1,6 -> TOTAL0 = 17; HIT, card 10 -> TOTAL0 = 17 (hard); HIT, card 5 -> BUST_V[0] = 1 and TURN auto-advances to seat1 the next cycle.
- Invalid card and stall: CARD_VLD with CARD = 0 -> no DEAL_VLD, CARD_REQ stays high; next card 12 -> DEAL_VAL = 10.
- Simultaneous HIT and STAND on the active seat -> seat held, no CARD_REQ, TURN advances; HIT on an inactive seat -> no effect.
- All seats bust -> dealer draws no cards (no CARD_REQ after seat play); WIN_V = 0, PUSH_V = 0; DONE = 1. Dealer soft 17 (1,6) -> no draw.
